// File: rtl/keypad_scan_hex.sv
// rtl/keypad_scan_hex.sv - 4x4 active-low matrix keypad scanner with debounce and hex output
module keypad_scan_hex #(
    parameter int SCAN_BITS = 16,
    parameter int DB_TICKS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    localparam logic [3:0] DB = 4'(DB_TICKS);

    logic [3:0]           sync1, rs;
    logic [SCAN_BITS-1:0] tick_cnt;
    logic                 tick;

    state_t     state, state_next;
    logic [1:0] c, c_next;
    logic [1:0] r_lat, r_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] key_next;
    logic       valid_next, down_next;

    logic       one_low;
    logic [1:0] rs_idx;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] cc);
        logic [3:0] k;
        case ({r, cc})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 4'b1111;
            rs       <= 4'b1111;
            tick_cnt <= '0;
        end else begin
            sync1    <= row;
            rs       <= sync1;
            tick_cnt <= tick_cnt + SCAN_BITS'(1);
        end
    end

    assign tick = &tick_cnt;
    assign col  = ~(4'b0001 << c);

    // A valid press is exactly one row low; several low rows are treated as ghosting.
    always_comb begin
        one_low = 1'b1;
        rs_idx  = 2'd0;
        case (rs)
            4'b1110: rs_idx = 2'd0;
            4'b1101: rs_idx = 2'd1;
            4'b1011: rs_idx = 2'd2;
            4'b0111: rs_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SCAN;
            c         <= 2'd0;
            r_lat     <= 2'd0;
            cnt       <= 4'd0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_next;
            c         <= c_next;
            r_lat     <= r_next;
            cnt       <= cnt_next;
            key       <= key_next;
            key_valid <= valid_next;
            key_down  <= down_next;
        end
    end

    always_comb begin
        state_next = state;
        c_next     = c;
        r_next     = r_lat;
        cnt_next   = cnt;
        key_next   = key;
        valid_next = 1'b0;
        down_next  = key_down;
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (one_low) begin
                        r_next     = rs_idx;
                        cnt_next   = 4'd0;
                        state_next = S_DEBOUNCE;
                    end else begin
                        c_next = c + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (rs == ~(4'b0001 << r_lat)) begin
                        if (cnt + 4'd1 == DB) begin
                            key_next   = key_code(r_lat, c);
                            valid_next = 1'b1;
                            down_next  = 1'b1;
                            cnt_next   = 4'd0;
                            state_next = S_HELD;
                        end else begin
                            cnt_next = cnt + 4'd1;
                        end
                    end else begin
                        state_next = S_SCAN;
                        c_next     = c + 2'd1;
                    end
                end
                S_HELD: begin
                    // Any low row restarts the release count, so release must be consecutive.
                    if (rs == 4'b1111) begin
                        if (cnt + 4'd1 == DB) begin
                            down_next  = 1'b0;
                            cnt_next   = 4'd0;
                            state_next = S_SCAN;
                            c_next     = c + 2'd1;
                        end else begin
                            cnt_next = cnt + 4'd1;
                        end
                    end else begin
                        cnt_next = 4'd0;
                    end
                end
                default: begin
                    state_next = S_SCAN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

endmodule
